// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller
//
// Programmable daily alarm that sits downstream of the time-of-day counter.
// It compares the running hr/min/sec (qualified by sec_tick) against an
// effective target time and rings when they meet. Snooze pushes the target
// forward by SNOOZE_MIN minutes with 24-hour wrap. Stop, ring timeout and
// disarm all restore the target to the programmed alarm time.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   hr/min/sec          current time of day, valid when sec_tick is high
//   sec_tick            one-cycle once-per-second strobe
//   set_valid/set_hr/set_min/set_ready
//                       alarm-load handshake (set_ready is combinational)
//   arm                 level; low forces DISARMED
//   snooze, stop        one-cycle requests while ringing/snoozed
//   alarm_out           registered, high while RINGING
//   state               DISARMED=0, ARMED=1, RINGING=2, SNOOZED=3
//   alarm_hr/alarm_min  programmed alarm time
//   snooze_cnt          snoozes taken in the current alarm event
//   err                 one-cycle pulse: invalid load rejected
//   missed              one-cycle pulse: ring timed out
// ---------------------------------------------------------------------------
module alarm_controller #(
  parameter int RING_SECS  = 30,  // 1..63 ticks per ring
  parameter int SNOOZE_MIN = 5,   // 1..59 minutes per snooze
  parameter int MAX_SNOOZE = 3    // 0..3 snoozes per event
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       sec_tick,
  input  logic       set_valid,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  output logic       set_ready,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm_out,
  output logic [1:0] state,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic [1:0] snooze_cnt,
  output logic       err,
  output logic       missed
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZED  = 2'd3
  } state_t;

  localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);
  localparam logic [6:0] SNZ_ADD   = 7'(SNOOZE_MIN);
  localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

  state_t     state_q;
  logic [4:0] tgt_hr;
  logic [5:0] tgt_min;
  logic [5:0] ring_cnt;

  logic       match;
  logic       load;
  logic       load_bad;
  logic       snz_ok;
  logic [6:0] snz_sum;
  logic [5:0] snz_min;
  logic [4:0] snz_hr;

  assign state     = state_q;
  assign set_ready = (state_q == DISARMED) || (state_q == ARMED);

  // Match is taken against the target as it stands before any load this cycle.
  assign match    = sec_tick && (hr == tgt_hr) && (min == tgt_min) && (sec == 6'd0);
  assign load     = set_valid && set_ready;
  assign load_bad = (set_hr > 5'd23) || (set_min > 6'd59);
  assign snz_ok   = snooze && (snooze_cnt < SNZ_MAX);

  // Target advanced by one snooze interval, carrying into the hour and
  // wrapping 23 -> 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    snz_sum = {1'b0, tgt_min} + SNZ_ADD;
    snz_min = snz_sum[5:0];
    snz_hr  = tgt_hr;
    if (snz_sum >= 7'd60) begin
      snz_min = 6'(snz_sum - 7'd60);
      snz_hr  = (tgt_hr == 5'd23) ? 5'd0 : tgt_hr + 5'd1;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DISARMED;
      alarm_hr   <= 5'd0;
      alarm_min  <= 6'd0;
      tgt_hr     <= 5'd0;
      tgt_min    <= 6'd0;
      ring_cnt   <= 6'd0;
      snooze_cnt <= 2'd0;
      alarm_out  <= 1'b0;
      err        <= 1'b0;
      missed     <= 1'b0;
    end else begin
      err    <= 1'b0;
      missed <= 1'b0;

      if (!arm) begin
        state_q    <= DISARMED;
        alarm_out  <= 1'b0;
        snooze_cnt <= 2'd0;
        tgt_hr     <= alarm_hr;
        tgt_min    <= alarm_min;
      end else begin
        case (state_q)
          DISARMED: state_q <= ARMED;

          ARMED: begin
            if (match) begin
              state_q   <= RINGING;
              alarm_out <= 1'b1;
              ring_cnt  <= 6'd0;
            end
          end

          RINGING: begin
            if (stop) begin
              state_q    <= ARMED;
              alarm_out  <= 1'b0;
              snooze_cnt <= 2'd0;
              tgt_hr     <= alarm_hr;
              tgt_min    <= alarm_min;
            end else if (snz_ok) begin
              state_q    <= SNOOZED;
              alarm_out  <= 1'b0;
              snooze_cnt <= snooze_cnt + 2'd1;
              tgt_hr     <= snz_hr;
              tgt_min    <= snz_min;
            end else if (sec_tick) begin
              // The tick that started the ring is not counted, so the last
              // of RING_SECS ticks lands on ring_cnt == RING_SECS-1.
              if (ring_cnt == RING_LAST) begin
                state_q    <= ARMED;
                alarm_out  <= 1'b0;
                snooze_cnt <= 2'd0;
                tgt_hr     <= alarm_hr;
                tgt_min    <= alarm_min;
                missed     <= 1'b1;
              end else begin
                ring_cnt <= ring_cnt + 6'd1;
              end
            end
          end

          SNOOZED: begin
            if (stop) begin
              state_q    <= ARMED;
              snooze_cnt <= 2'd0;
              tgt_hr     <= alarm_hr;
              tgt_min    <= alarm_min;
            end else if (match) begin
              state_q   <= RINGING;
              alarm_out <= 1'b1;
              ring_cnt  <= 6'd0;
            end
          end

          default: state_q <= DISARMED;
        endcase
      end

      // A load is only possible in DISARMED/ARMED. Placed last so a valid load
      // overrides the target restore done by a same-cycle disarm.
      if (load) begin
        if (load_bad) begin
          err <= 1'b1;
        end else begin
          alarm_hr  <= set_hr;
          alarm_min <= set_min;
          tgt_hr    <= set_hr;
          tgt_min   <= set_min;
        end
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_controller
//
// Drives alarm_controller with a table of alarm loads, directed sequences for
// the multi-cycle corner cases (ring, snooze with midnight wrap, snooze limit,
// timeout, blocked load, disarm, asynchronous reset) and a randomized phase.
// Every cycle all outputs are compared against a reference model that keeps
// times as minutes-of-day and the ring as a countdown of remaining ticks.
// ---------------------------------------------------------------------------
module tb_alarm_controller;

  localparam int RING_SECS  = 30;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_tick;
  logic       set_valid;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       set_ready;
  logic       arm;
  logic       snooze;
  logic       stop;
  logic       alarm_out;
  logic [1:0] state;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic [1:0] snooze_cnt;
  logic       err;
  logic       missed;

  alarm_controller #(
    .RING_SECS (RING_SECS),
    .SNOOZE_MIN(SNOOZE_MIN),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hr        (hr),
    .min       (min),
    .sec       (sec),
    .sec_tick  (sec_tick),
    .set_valid (set_valid),
    .set_hr    (set_hr),
    .set_min   (set_min),
    .set_ready (set_ready),
    .arm       (arm),
    .snooze    (snooze),
    .stop      (stop),
    .alarm_out (alarm_out),
    .state     (state),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .snooze_cnt(snooze_cnt),
    .err       (err),
    .missed    (missed)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: times in minutes since midnight, ring as ticks remaining.
  // State codes: 0 idle/disarmed, 1 waiting, 2 ringing, 3 snoozed.
  int m_state;
  int m_alarm;
  int m_tgt;
  int m_ring_left;
  int m_snz;
  bit m_err;
  bit m_missed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state     = 0;
    m_alarm     = 0;
    m_tgt       = 0;
    m_ring_left = 0;
    m_snz       = 0;
    m_err       = 1'b0;
    m_missed    = 1'b0;
  endtask

  // Ends an alarm event: back to waiting for the programmed time.
  task automatic model_end_event();
    m_state = 1;
    m_snz   = 0;
    m_tgt   = m_alarm;
  endtask

  task automatic model_step();
    bit ready;
    bit hit;
    ready    = (m_state == 0) || (m_state == 1);
    hit      = sec_tick && (sec == 6'd0) && (int'(hr) * 60 + int'(min) == m_tgt);
    m_err    = 1'b0;
    m_missed = 1'b0;
    if (!arm) begin
      m_state = 0;
      m_snz   = 0;
      m_tgt   = m_alarm;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 2) begin
      if (stop) begin
        model_end_event();
      end else if (snooze && m_snz < MAX_SNOOZE) begin
        m_state = 3;
        m_snz++;
        m_tgt = (m_tgt + SNOOZE_MIN) % 1440;
      end else if (sec_tick) begin
        m_ring_left--;
        if (m_ring_left == 0) begin
          model_end_event();
          m_missed = 1'b1;
        end
      end
    end else begin
      if (m_state == 3 && stop) begin
        model_end_event();
      end else if (hit) begin
        m_state     = 2;
        m_ring_left = RING_SECS;
      end
    end
    if (set_valid && ready) begin
      if (set_hr > 5'd23 || set_min > 6'd59) begin
        m_err = 1'b1;
      end else begin
        m_alarm = int'(set_hr) * 60 + int'(set_min);
        m_tgt   = m_alarm;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},      32'(state),      32'(m_state));
    check({tag, ".alarm_out"},  32'(alarm_out),  32'(m_state == 2));
    check({tag, ".alarm_hr"},   32'(alarm_hr),   32'(m_alarm / 60));
    check({tag, ".alarm_min"},  32'(alarm_min),  32'(m_alarm % 60));
    check({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(m_snz));
    check({tag, ".err"},        32'(err),        32'(m_err));
    check({tag, ".missed"},     32'(missed),     32'(m_missed));
    check({tag, ".set_ready"},  32'(set_ready),  32'(m_state <= 1));
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic tick_at(input int h, input int m, input int s, input string tag);
    hr       = 5'(h);
    min      = 6'(m);
    sec      = 6'(s);
    sec_tick = 1'b1;
    cycle(tag);
    sec_tick = 1'b0;
  endtask

  task automatic pulse_snooze(input string tag);
    snooze = 1'b1;
    cycle(tag);
    snooze = 1'b0;
  endtask

  task automatic pulse_stop(input string tag);
    stop = 1'b1;
    cycle(tag);
    stop = 1'b0;
  endtask

  task automatic load(input int h, input int m, input string tag);
    set_valid = 1'b1;
    set_hr    = 5'(h);
    set_min   = 6'(m);
    cycle(tag);
    set_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0] hr;
    logic [5:0] mn;
    bit         exp_err;
    int         exp_hr;
    int         exp_min;
  } load_vec_t;

  load_vec_t lv[7];

  initial begin
    lv[0] = '{5'd7,  6'd30, 1'b0, 7,  30};
    lv[1] = '{5'd24, 6'd10, 1'b1, 7,  30};
    lv[2] = '{5'd12, 6'd60, 1'b1, 7,  30};
    lv[3] = '{5'd23, 6'd59, 1'b0, 23, 59};
    lv[4] = '{5'd31, 6'd63, 1'b1, 23, 59};
    lv[5] = '{5'd0,  6'd0,  1'b0, 0,  0};
    lv[6] = '{5'd7,  6'd30, 1'b0, 7,  30};

    rst_n = 1'b0; hr = '0; min = '0; sec = '0; sec_tick = 1'b0;
    set_valid = 1'b0; set_hr = '0; set_min = '0;
    arm = 1'b0; snooze = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 32'(state), 0);
    check("reset.alarm_out", 32'(alarm_out), 0);
    check("reset.set_ready", 32'(set_ready), 1);
    check_all("reset");
    rst_n = 1'b1;

    // Load table while disarmed.
    for (int i = 0; i < 7; i++) begin
      set_valid = 1'b1;
      set_hr    = lv[i].hr;
      set_min   = lv[i].mn;
      cycle($sformatf("load%0d", i));
      check($sformatf("load%0d.err", i),       32'(err),       32'(lv[i].exp_err));
      check($sformatf("load%0d.alarm_hr", i),  32'(alarm_hr),  32'(lv[i].exp_hr));
      check($sformatf("load%0d.alarm_min", i), 32'(alarm_min), 32'(lv[i].exp_min));
      set_valid = 1'b0;
      cycle($sformatf("load%0d_idle", i));
      check($sformatf("load%0d_idle.err", i), 32'(err), 0);
    end

    // Arm and ring at 07:30:00.
    arm = 1'b1;
    cycle("arm");
    check("arm.state", 32'(state), 1);
    tick_at(7, 29, 59, "pre");
    check("pre.state", 32'(state), 1);
    hr = 5'd7; min = 6'd30; sec = 6'd0;
    cycle("no_tick");
    check("no_tick.state", 32'(state), 1);
    tick_at(7, 30, 1, "sec1");
    check("sec1.state", 32'(state), 1);
    tick_at(7, 30, 0, "ring730");
    check("ring730.state", 32'(state), 2);
    check("ring730.alarm_out", 32'(alarm_out), 1);

    // Snooze to 07:35, ring again, then let it time out.
    pulse_snooze("snz1");
    check("snz1.state", 32'(state), 3);
    tick_at(7, 35, 0, "ring735");
    check("ring735.state", 32'(state), 2);
    for (int i = 1; i < RING_SECS; i++) begin
      tick_at(7, 35, i, "ringing");
      if (i % 4 == 0) cycle("ring_gap");
    end
    check("pre_timeout.state", 32'(state), 2);
    tick_at(7, 35, 30, "timeout");
    check("timeout.missed", 32'(missed), 1);
    check("timeout.state", 32'(state), 1);
    check("timeout.alarm_out", 32'(alarm_out), 0);
    check("timeout.snooze_cnt", 32'(snooze_cnt), 0);
    cycle("post_timeout");
    check("post_timeout.missed", 32'(missed), 0);
    tick_at(7, 35, 0, "old_tgt");
    check("old_tgt.state", 32'(state), 1);
    tick_at(7, 30, 0, "restored");
    check("restored.state", 32'(state), 2);
    pulse_stop("stop1");
    check("stop1.state", 32'(state), 1);

    // Snooze across midnight.
    load(23, 58, "load2358");
    tick_at(23, 58, 0, "ring2358");
    check("ring2358.state", 32'(state), 2);
    pulse_snooze("wrap");
    check("wrap.state", 32'(state), 3);
    check("wrap.snooze_cnt", 32'(snooze_cnt), 1);
    tick_at(23, 58, 0, "wrap_old");
    check("wrap_old.state", 32'(state), 3);
    tick_at(0, 3, 0, "ring0003");
    check("ring0003.state", 32'(state), 2);

    // Snooze limit.
    pulse_snooze("snz2");
    tick_at(0, 8, 0, "ring0008");
    pulse_snooze("snz3");
    check("snz3.snooze_cnt", 32'(snooze_cnt), 3);
    tick_at(0, 13, 0, "ring0013");
    pulse_snooze("snz4");
    check("snz4.state", 32'(state), 2);
    check("snz4.snooze_cnt", 32'(snooze_cnt), 3);

    // Load blocked while ringing.
    set_valid = 1'b1; set_hr = 5'd1; set_min = 6'd1;
    check("blocked.set_ready", 32'(set_ready), 0);
    cycle("blocked");
    set_valid = 1'b0;
    check("blocked.alarm_hr", 32'(alarm_hr), 23);
    check("blocked.alarm_min", 32'(alarm_min), 58);

    // Stop and snooze together: stop wins.
    stop = 1'b1; snooze = 1'b1;
    cycle("stop_snz");
    stop = 1'b0; snooze = 1'b0;
    check("stop_snz.state", 32'(state), 1);
    check("stop_snz.snooze_cnt", 32'(snooze_cnt), 0);

    // Disarm while snoozed, re-arm, ring, then asynchronous reset.
    tick_at(23, 58, 0, "ring_b");
    pulse_snooze("snz_b");
    arm = 1'b0;
    cycle("disarm");
    check("disarm.state", 32'(state), 0);
    check("disarm.snooze_cnt", 32'(snooze_cnt), 0);
    arm = 1'b1;
    cycle("rearm");
    tick_at(23, 58, 0, "ring_c");
    check("ring_c.alarm_out", 32'(alarm_out), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst.alarm_out", 32'(alarm_out), 0);
    check("async_rst.state", 32'(state), 0);
    model_reset();
    check_all("async_rst");
    cycle("in_reset");
    rst_n = 1'b1;

    // Randomized phase; hr/min are biased toward the model target so rings occur.
    for (int n = 0; n < 4000; n++) begin
      arm       = ($urandom_range(99) != 0);
      stop      = ($urandom_range(39) == 0);
      sec_tick  = ($urandom_range(2) == 0);
      snooze    = !sec_tick && ($urandom_range(5) == 0);
      set_valid = ($urandom_range(9) == 0);
      set_hr    = 5'($urandom_range(31));
      set_min   = 6'($urandom_range(63));
      if ($urandom_range(3) == 0) begin
        hr  = 5'(m_tgt / 60);
        min = 6'(m_tgt % 60);
        sec = 6'd0;
      end else begin
        hr  = 5'($urandom_range(23));
        min = 6'($urandom_range(59));
        sec = 6'($urandom_range(59));
      end
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
